// File: rtl/bin_to_gray_counter.sv
// Binary up/down counter with a registered Gray-code view of the same count.
// Both views load from one next-state value, so they update together with no skew.
module bin_to_gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray is encoded from the next binary value so both registers stay coherent.
  always_comb begin
    bin_d  = bin_q;
    gray_d = gray_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d  = load_bin;
      gray_d = to_gray(load_bin);
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + ONE;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = ~|bin_q;
      end
      gray_d = to_gray(bin_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Scoreboard bench for bin_to_gray_counter at WIDTH=4: expected values are queued
// when stimulus is driven and popped once the clock edge has produced the output.
module tb_bin_to_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, en, up_dn, load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin, gray;
  logic         wrap;

  typedef struct {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         w;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_bin;
  logic         m_wrap;
  int           checks = 0;
  int           errors = 0;

  bin_to_gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .bin(bin), .gray(gray), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gray_model(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W-1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  function automatic logic [W-1:0] gray_decode(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [W-1:0] lb);
    exp_t x;
    rst = r; en = e; up_dn = u; load = l; load_bin = lb;
    if (r) begin
      m_bin = '0; m_wrap = 1'b0;
    end else if (l) begin
      m_bin = lb; m_wrap = 1'b0;
    end else if (e && u) begin
      m_wrap = (m_bin == 4'hF); m_bin = m_bin + 4'd1;
    end else if (e) begin
      m_wrap = (m_bin == 4'h0); m_bin = m_bin - 4'd1;
    end else begin
      m_wrap = 1'b0;
    end
    x.b = m_bin; x.g = gray_model(m_bin); x.w = m_wrap;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      x = sb.pop_front();
      checks++;
      if ({bin, gray, wrap} !== {x.b, x.g, x.w} || {bin, gray, wrap} !== 9'b0) begin
        errors++;
        $display("FAIL reset%0d got bin=%h gray=%h wrap=%b want 0 0 0", i, bin, gray, wrap);
      end
    end
  endtask

  task automatic test_up_count();
    exp_t x;
    logic [W-1:0] tbl [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                               4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                               4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    logic [W-1:0] prev;
    for (int k = 1; k <= 16; k++) begin
      prev = gray;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      x = sb.pop_front();
      checks++;
      if (gray !== tbl[k] || bin !== x.b || wrap !== (k == 16)) begin
        errors++;
        $display("FAIL up_step%0d got bin=%h gray=%b wrap=%b want bin=%h gray=%b wrap=%b",
                 k, bin, gray, wrap, x.b, tbl[k], (k == 16));
      end
      checks++;
      if ($countones(gray ^ prev) != 1) begin
        errors++;
        $display("FAIL up_hamming%0d got %b->%b want distance 1", k, prev, gray);
      end
    end
  endtask

  task automatic test_down_count();
    exp_t x;
    logic [W-1:0] tb_b [3] = '{4'b1111, 4'b1110, 4'b1101};
    logic [W-1:0] tb_g [3] = '{4'b1000, 4'b1001, 4'b1011};
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    void'(sb.pop_front());
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      x = sb.pop_front();
      checks++;
      if (bin !== tb_b[k] || gray !== tb_g[k] || wrap !== (k == 0) ||
          {bin, gray, wrap} !== {x.b, x.g, x.w}) begin
        errors++;
        $display("FAIL down%0d got bin=%b gray=%b wrap=%b want bin=%b gray=%b wrap=%b",
                 k, bin, gray, wrap, tb_b[k], tb_g[k], (k == 0));
      end
    end
  endtask

  task automatic test_load();
    exp_t x;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010);
    x = sb.pop_front();
    checks++;
    if ({bin, gray, wrap} !== {4'b1010, 4'b1111, 1'b0} || {bin, gray, wrap} !== {x.b, x.g, x.w}) begin
      errors++;
      $display("FAIL load got bin=%b gray=%b wrap=%b want 1010 1111 0", bin, gray, wrap);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    x = sb.pop_front();
    checks++;
    if ({bin, gray, wrap} !== {4'b1011, 4'b1110, 1'b0} || {bin, gray, wrap} !== {x.b, x.g, x.w}) begin
      errors++;
      $display("FAIL load_inc got bin=%b gray=%b wrap=%b want 1011 1110 0", bin, gray, wrap);
    end
  endtask

  task automatic test_priority();
    exp_t x;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
    x = sb.pop_front();
    checks++;
    if ({bin, gray, wrap} !== {4'b1111, 4'b1000, 1'b0} || {bin, gray, wrap} !== {x.b, x.g, x.w}) begin
      errors++;
      $display("FAIL prio_load got bin=%b gray=%b wrap=%b want 1111 1000 0", bin, gray, wrap);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    x = sb.pop_front();
    checks++;
    if ({bin, gray, wrap} !== {4'b0000, 4'b0000, 1'b1} || {bin, gray, wrap} !== {x.b, x.g, x.w}) begin
      errors++;
      $display("FAIL prio_wrap got bin=%b gray=%b wrap=%b want 0000 0000 1", bin, gray, wrap);
    end
  endtask

  task automatic test_mid_reset_hold();
    exp_t x;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    void'(sb.pop_front());
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      void'(sb.pop_front());
    end
    checks++;
    if (bin !== 4'b0110 || gray !== 4'b0101) begin
      errors++;
      $display("FAIL count_to_6 got bin=%b gray=%b want 0110 0101", bin, gray);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
    x = sb.pop_front();
    checks++;
    if ({bin, gray, wrap} !== 9'b0 || {bin, gray, wrap} !== {x.b, x.g, x.w}) begin
      errors++;
      $display("FAIL mid_reset got bin=%b gray=%b wrap=%b want 0000 0000 0", bin, gray, wrap);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 4'hA);
      x = sb.pop_front();
      checks++;
      if ({bin, gray, wrap} !== 9'b0 || {bin, gray, wrap} !== {x.b, x.g, x.w}) begin
        errors++;
        $display("FAIL hold%0d got bin=%b gray=%b wrap=%b want 0000 0000 0", k, bin, gray, wrap);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic [W-1:0] prev;
    logic dir [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    void'(sb.pop_front());
    for (int k = 0; k < 6; k++) begin
      prev = gray;
      drive(1'b0, 1'b1, dir[k], 1'b0, 4'h0);
      x = sb.pop_front();
      checks++;
      if ({bin, gray, wrap} !== {x.b, x.g, x.w} || $countones(gray ^ prev) != 1) begin
        errors++;
        $display("FAIL dir_step%0d got bin=%b gray=%b wrap=%b want bin=%b gray=%b wrap=%b",
                 k, bin, gray, wrap, x.b, x.g, x.w);
      end
    end
  endtask

  task automatic test_round_trip();
    exp_t x;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
    void'(sb.pop_front());
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      x = sb.pop_front();
      checks++;
      if (gray_decode(gray) !== bin || bin !== x.b || wrap !== x.w) begin
        errors++;
        $display("FAIL round_trip%0d got decoded=%b bin=%b wrap=%b want bin=%b wrap=%b",
                 k, gray_decode(gray), bin, wrap, x.b, x.w);
      end
    end
  endtask

  initial begin
    m_bin = '0; m_wrap = 1'b0;
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_priority();
    test_mid_reset_hold();
    test_back_to_back();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_to_gray_counter.md
Name: bin_to_gray_counter

Overview:
- Synchronous binary up/down counter that also drives a registered Gray-code view of the count.
- This is the encode side of the Gray/binary pair. It produces the Gray sequences that the existing Gray-to-binary decoder consumes.
- Intended use: Gray-coded pointer/count source for lab-level clock-crossing and encoder experiments.
- Both the binary and Gray outputs update on the same clock edge.

Parameters:
- WIDTH, 4, bit width of the count, the binary output and the Gray output (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- en  input  1  count enable; when high, count advances by one step per clock.
- up_dn  input  1  direction; 1 = increment, 0 = decrement. Sampled only when en=1.
- load  input  1  synchronous load strobe.
- load_bin  input  WIDTH  binary value captured when load=1.
- bin  output  WIDTH  registered binary count.
- gray  output  WIDTH  registered Gray code of bin.
- wrap  output  1  one-cycle pulse when the count rolls over.

Behaviour:
- Reset:
  - Reset is synchronous, active-high. On a rising clk edge with rst=1: bin=0, gray=0, wrap=0.
  - rst overrides load and en.
  - Reset asserted mid-count clears everything on that edge. No partial step is taken.
- Priority at each rising edge: rst > load > en > hold.
- Load (rst=0, load=1):
  - bin <= load_bin; gray <= load_bin ^ (load_bin >> 1); wrap <= 0.
  - en and up_dn are ignored on that cycle.
  - A loaded value never produces a wrap pulse, even when it is all-ones or zero.
- Count (rst=0, load=0, en=1):
  - next = bin + 1 if up_dn=1, otherwise bin - 1, modulo 2^WIDTH.
  - bin <= next; gray <= next ^ (next >> 1).
- Hold (rst=0, load=0, en=0): bin and gray keep their values; wrap <= 0.
- Gray encoding rules:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[i] = bin[i+1] ^ bin[i] for i < WIDTH-1.
  - gray is computed from the next binary value, not the current one, so gray and bin are always coherent in the same cycle. There is zero cycles of skew between them.
- Wrap:
  - wrap <= 1 for exactly one cycle when an up-count steps from 2^WIDTH-1 to 0.
  - wrap <= 1 for exactly one cycle when a down-count steps from 0 to 2^WIDTH-1.
  - wrap is 0 on every other cycle.
  - Consecutive wraps (for example WIDTH=2 counting continuously) each produce their own pulse.
- Latency: outputs reflect an input change at the first rising edge where it is sampled. There is no additional pipeline stage.
- Single-step invariant: on any count cycle, exactly one bit of gray changes (Hamming distance 1), including across wrap.
- Direction change: if up_dn toggles between enabled cycles, the count reverses immediately with no dead cycle, and the invariant still holds.
- Internally a single WIDTH-bit binary register and a WIDTH-bit Gray register are kept. No other state is held.

Test Plan:
- Reset then up-count: hold rst=1 for 2 cycles, then en=1, up_dn=1 for 16 cycles.
  - Required: gray = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
  - Required: wrap=1 only on the 1000->0000 cycle.
  - Required: every step has Hamming distance 1.
- Down-count from zero: after reset, en=1, up_dn=0 for 3 cycles.
  - Required: bin = 1111, 1110, 1101 and gray = 1000, 1001, 1011.
  - Required: wrap=1 only on the first cycle.
- Load: load=1, load_bin=1010 for one cycle.
  - Required: next edge gives bin=1010, gray=1111, wrap=0.
  - Then en=1, up_dn=1 for one cycle. Required: bin=1011, gray=1110.
- Priority: load=1, en=1, up_dn=1, load_bin=1111 in the same cycle.
  - Required: bin=1111, gray=1000, wrap=0 (load wins, no wrap).
  - Next cycle with load=0, en=1. Required: bin=0000, gray=0000, wrap=1.
- Mid-operation reset and hold:
  - Count up to bin=0110, then assert rst=1 together with en=1 and load=1. Required: bin=0000, gray=0000, wrap=0.
  - Then en=0 for 5 cycles. Required: outputs stay at 0000.
- Round-trip: drive gray into the existing Gray-to-binary decoder over a full up-count cycle. Required: decoded value equals bin on every cycle.
